// File: rtl/tc_pl_bus_spi_ctrl.sv
// SPI mode-0 master sequencer for the shared PL serial bus (ADC0, FDA0, DAC0, DAC1, LPL0).
// Handles one command at a time, and every output is driven directly from a register.
module tc_pl_bus_spi_ctrl #(
  parameter int AGP0_25  = 8,
  parameter int DW       = 32,
  parameter int DIV_HALF = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_dev,
  input  logic [5:0]         cmd_len,
  input  logic [DW-1:0]      cmd_wdata,
  output logic               rsp_valid,
  output logic               rsp_err,
  output logic [DW-1:0]      rsp_rdata,
  output logic               busy,
  output logic [AGP0_25-1:0] chip_sel,
  output logic               spi_CSN,
  output logic               spi_SCLK,
  output logic               spi_MOSI,
  input  logic               spi_MISO
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

  state_e               state_q;
  logic [7:0]           cnt_q;
  logic [7:0]           div_q;
  logic [5:0]           bit_q;
  logic [DW-1:0]        tx_q;
  logic [DW-1:0]        rx_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 rsp_valid_q;
  logic                 rsp_err_q;
  logic [DW-1:0]        rsp_rdata_q;
  logic [AGP0_25-1:0]   chip_sel_q;
  logic                 csn_q;
  logic                 sclk_q;
  logic                 mosi_q;

  logic                 cmd_err_d;
  logic [DW-1:0]        tx_init_d;
  logic [AGP0_25-1:0]   sel_init_d;

  // The write word is MSB-aligned at accept, so the bit on the wire is always tx_q[DW-1].
  always_comb begin
    cmd_err_d  = (cmd_dev >= 3'd5) || ({29'd0, cmd_dev} >= 32'(AGP0_25)) ||
                 (cmd_len == 6'd0) || ({26'd0, cmd_len} > 32'(DW));
    tx_init_d  = cmd_wdata << (7'(DW) - {1'b0, cmd_len});
    sel_init_d = {{(AGP0_25-1){1'b0}}, 1'b1} << cmd_dev;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      chip_sel_q  <= '0;
      csn_q       <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (cmd_err_d) begin
              // Rejected commands skip the bus entirely but still honour the CSN gap.
              state_q     <= GAP;
              cnt_q       <= 8'(CS_GAP - 1);
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q    <= SETUP;
              cnt_q      <= 8'(CS_SETUP - 1);
              chip_sel_q <= sel_init_d;
              csn_q      <= 1'b0;
              tx_q       <= tx_init_d;
              mosi_q     <= tx_init_d[DW-1];
              rx_q       <= '0;
              bit_q      <= cmd_len;
            end
          end
        end
        SETUP: begin
          if (cnt_q == 8'd0) begin
            state_q <= SHIFT;
            div_q   <= 8'(DIV_HALF - 1);
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        SHIFT: begin
          if (div_q != 8'd0) begin
            div_q <= div_q - 8'd1;
          end else if (!sclk_q) begin
            sclk_q <= 1'b1;
            rx_q   <= {rx_q[DW-2:0], spi_MISO};
            div_q  <= 8'(DIV_HALF - 1);
          end else begin
            sclk_q <= 1'b0;
            div_q  <= 8'(DIV_HALF - 1);
            bit_q  <= bit_q - 6'd1;
            if (bit_q == 6'd1) begin
              state_q <= HOLD;
              cnt_q   <= 8'(CS_HOLD - 1);
            end else begin
              tx_q   <= tx_q << 1;
              mosi_q <= tx_q[DW-2];
            end
          end
        end
        HOLD: begin
          if (cnt_q == 8'd0) begin
            state_q     <= GAP;
            cnt_q       <= 8'(CS_GAP - 1);
            csn_q       <= 1'b1;
            chip_sel_q  <= '0;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= rx_q;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        GAP: begin
          if (cnt_q == 8'd0) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign chip_sel  = chip_sel_q;
  assign spi_CSN   = csn_q;
  assign spi_SCLK  = sclk_q;
  assign spi_MOSI  = mosi_q;

endmodule

// File: tb/tb_tc_pl_bus_spi_ctrl.sv
// Directed bench for tc_pl_bus_spi_ctrl: a vector table of single transfers plus
// hand-written back-to-back and mid-transfer reset sequences.
module tb_tc_pl_bus_spi_ctrl;

  localparam int CS_GAP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_dev = 3'd0;
  logic [5:0]  cmd_len = 6'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic [7:0]  chip_sel;
  logic        spi_CSN;
  logic        spi_SCLK;
  logic        spi_MOSI;
  logic        spi_MISO;

  tc_pl_bus_spi_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dev   (cmd_dev),
    .cmd_len   (cmd_len),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .chip_sel  (chip_sel),
    .spi_CSN   (spi_CSN),
    .spi_SCLK  (spi_SCLK),
    .spi_MOSI  (spi_MOSI),
    .spi_MISO  (spi_MISO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  dev;
    logic [5:0]  len;
    logic [31:0] wdata;
    logic [31:0] miso;
    logic        err;
    logic [31:0] rdata;
    logic [7:0]  sel;
    int          pulses;
    int          lat;
    logic [31:0] mosi;
  } vec_t;

  vec_t vecs [9];

  int passed = 0;
  int total = 0;

  // Bus-side model: counts SCLK rising edges, records MOSI, plays a slave word on MISO.
  int          rises = 0;
  int          rises_base = 0;
  logic [31:0] mosi_cap = 32'd0;
  int          cur_len = 0;
  logic [31:0] cur_miso = 32'd0;
  int          viol = 0;

  always @(posedge spi_SCLK) begin
    rises    <= rises + 1;
    mosi_cap <= {mosi_cap[30:0], spi_MOSI};
  end

  always @(negedge spi_SCLK or negedge spi_CSN) begin
    int idx;
    idx = cur_len - 1 - (rises - rises_base);
    spi_MISO = (idx >= 0 && idx < 32) ? cur_miso[idx] : 1'b0;
  end

  always @(negedge clk) begin
    if (spi_CSN && (spi_SCLK || chip_sel != 8'd0)) viol <= viol + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int          waited;
    int          n;
    int          sel_bad;
    int          base;
    logic [31:0] mask;
    wait_ready();
    base       = rises;
    rises_base = rises;
    cur_len    = int'(v.len);
    cur_miso   = v.miso;
    cmd_dev    = v.dev;
    cmd_len    = v.len;
    cmd_wdata  = v.wdata;
    cmd_valid  = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check($sformatf("v%0d_sel_t1", id), 32'(chip_sel), 32'(v.sel));
    check($sformatf("v%0d_csn_t1", id), 32'(spi_CSN), 32'(v.err));
    check($sformatf("v%0d_busy_t1", id), 32'(busy), 32'd1);
    if (!v.err) check($sformatf("v%0d_mosi_first", id), 32'(spi_MOSI), 32'(v.mosi[v.len-6'd1]));
    waited  = 0;
    sel_bad = 0;
    while (!rsp_valid && waited < 400) begin
      if (!spi_CSN && chip_sel != v.sel) sel_bad++;
      @(negedge clk);
      waited++;
    end
    check($sformatf("v%0d_latency", id), 32'(waited + 1), 32'(v.lat));
    check($sformatf("v%0d_rsp_err", id), 32'(rsp_err), 32'(v.err));
    check($sformatf("v%0d_rdata", id), rsp_rdata, v.rdata);
    check($sformatf("v%0d_sclk_pulses", id), 32'(rises - base), 32'(v.pulses));
    check($sformatf("v%0d_sel_stable", id), 32'(sel_bad), 32'd0);
    check($sformatf("v%0d_csn_at_rsp", id), 32'(spi_CSN), 32'd1);
    mask = (v.len >= 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << v.len) - 32'd1);
    if (!v.err) check($sformatf("v%0d_mosi_stream", id), mosi_cap & mask, v.mosi);
    @(negedge clk);
    check($sformatf("v%0d_rsp_pulse", id), 32'(rsp_valid), 32'd0);
    n = 1;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("v%0d_busy_drop", id), 32'(n), 32'(CS_GAP));
    check($sformatf("v%0d_ready_idle", id), 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int n;
    int phase;
    int gap;
    int pulses;
    int rsp_seen;
    logic [7:0] sel2;

    //            dev   len    wdata          miso           err   rdata          sel    pls lat  mosi
    vecs[0] = '{3'd2, 6'd16, 32'h0000_A55A, 32'h0000_0000, 1'b0, 32'h0000_0000, 8'h04, 16, 133, 32'h0000_A55A};
    vecs[1] = '{3'd0, 6'd24, 32'h0012_3456, 32'h003C_0F81, 1'b0, 32'h003C_0F81, 8'h01, 24, 197, 32'h0012_3456};
    vecs[2] = '{3'd3, 6'd32, 32'h8000_0001, 32'hC000_0003, 1'b0, 32'hC000_0003, 8'h08, 32, 261, 32'h8000_0001};
    vecs[3] = '{3'd4, 6'd1,  32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0001, 8'h10, 1,  13,  32'h0000_0001};
    vecs[4] = '{3'd1, 6'd8,  32'hFFFF_FF3C, 32'h0000_00A5, 1'b0, 32'h0000_00A5, 8'h02, 8,  69,  32'h0000_003C};
    vecs[5] = '{3'd5, 6'd8,  32'h0000_00FF, 32'h0000_0000, 1'b1, 32'h0000_0000, 8'h00, 0,  1,   32'h0000_0000};
    vecs[6] = '{3'd0, 6'd0,  32'h0000_00FF, 32'h0000_0000, 1'b1, 32'h0000_0000, 8'h00, 0,  1,   32'h0000_0000};
    vecs[7] = '{3'd1, 6'd33, 32'h0000_00FF, 32'h0000_0000, 1'b1, 32'h0000_0000, 8'h00, 0,  1,   32'h0000_0000};
    vecs[8] = '{3'd7, 6'd4,  32'h0000_000F, 32'h0000_0000, 1'b1, 32'h0000_0000, 8'h00, 0,  1,   32'h0000_0000};

    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_chip_sel", 32'(chip_sel), 32'd0);
    check("rst_csn", 32'(spi_CSN), 32'd1);
    check("rst_sclk", 32'(spi_SCLK), 32'd0);
    check("rst_mosi", 32'(spi_MOSI), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], i);
      $display("vec %0d dev=%0d len=%0d wdata=0x%08h -> err=%0b rdata=0x%08h", i, vecs[i].dev,
               vecs[i].len, vecs[i].wdata, rsp_err, rsp_rdata);
    end

    // Back-to-back: cmd_valid held high across two commands.
    wait_ready();
    rises_base = rises;
    cur_len    = 4;
    cur_miso   = 32'd0;
    cmd_dev    = 3'd1;
    cmd_len    = 6'd4;
    cmd_wdata  = 32'h9;
    cmd_valid  = 1'b1;
    @(negedge clk);
    check("b2b_ready_low", 32'(cmd_ready), 32'd0);
    cmd_dev   = 3'd2;
    cmd_wdata = 32'h6;
    phase  = 0;
    gap    = 0;
    pulses = 0;
    sel2   = 8'd0;
    n      = 0;
    while (phase != 3 && n < 400) begin
      if (rsp_valid) pulses++;
      if (phase == 0 && rsp_valid && spi_CSN) phase = 1;
      if (phase == 1) begin
        if (spi_CSN) gap++;
        else begin
          phase     = 2;
          sel2      = chip_sel;
          cmd_valid = 1'b0;
          rises_base = rises;
        end
      end else if (phase == 2 && rsp_valid) begin
        phase = 3;
      end
      if (phase != 3) begin
        @(negedge clk);
        n++;
      end
    end
    cmd_valid = 1'b0;
    check("b2b_done", 32'(phase), 32'd3);
    check("b2b_csn_gap", 32'(gap), 32'(CS_GAP + 1));
    check("b2b_rsp_pulses", 32'(pulses), 32'd2);
    check("b2b_second_sel", 32'(sel2), 32'h04);
    check("b2b_second_mosi", mosi_cap & 32'hF, 32'h6);
    $display("b2b gap=%0d pulses=%0d sel2=0x%02h", gap, pulses, sel2);

    // Asynchronous reset while bit 5 of a 16-bit transfer is on the wire.
    wait_ready();
    rises_base = rises;
    n          = rises;
    cur_len    = 16;
    cur_miso   = 32'h0000_FFFF;
    cmd_dev    = 3'd2;
    cmd_len    = 6'd16;
    cmd_wdata  = 32'h0000_FFFF;
    cmd_valid  = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    phase = 0;
    while (!((rises - n) == 5 && spi_SCLK) && phase < 500) begin
      @(negedge clk);
      phase++;
    end
    check("arst_reached_bit5", 32'(rises - n), 32'd5);
    check("arst_csn_before", 32'(spi_CSN), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("arst_csn", 32'(spi_CSN), 32'd1);
    check("arst_sclk", 32'(spi_SCLK), 32'd0);
    check("arst_chip_sel", 32'(chip_sel), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ready", 32'(cmd_ready), 32'd1);
    rsp_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
    end
    rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
    end
    check("arst_no_rsp", 32'(rsp_seen), 32'd0);
    $display("async reset mid-shift: csn=%0b sclk=%0b rsp_seen=%0d", spi_CSN, spi_SCLK, rsp_seen);

    run_vec(vecs[0], 9);
    $display("post-reset transfer rdata=0x%08h err=%0b", rsp_rdata, rsp_err);

    check("bus_rule_violations", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
